// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver.
//   rx_state_t  : receiver FSM states
//   BAUD_TABLE  : baud rate for each 3-bit baud select code
//   baud_div()  : oversampling tick divisor, rounded to nearest, clamped to 1..65535
package uart_rx_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int unsigned BAUD_TABLE [8] = '{
        1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200
    };

    function automatic logic [15:0] baud_div(input int unsigned clk_freq,
                                             input logic [2:0]  sel,
                                             input int unsigned oversample = 16);
        int unsigned step;
        int unsigned q;
        step = oversample * BAUD_TABLE[sel];
        q    = (clk_freq + step / 2) / step;
        if (q == 0)     q = 1;
        if (q > 65535)  q = 65535;
        return q[15:0];
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator.
//   clk_i   : system clock
//   rst_n   : synchronous active-high reset
//   clear_i : hold the counter at zero and suppress ticks
//   div_i   : clocks per tick (>= 1)
//   tick_o  : one-cycle strobe every div_i clocks while clear_i is low
module uart_baud_gen (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic [15:0] div_i,
    output logic        tick_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        at_end;

    always_comb begin
        at_end = (cnt_q == div_i - 16'd1);
        tick_o = at_end & ~clear_i;
        if (clear_i || at_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with runtime baud select and 16x oversampling.
//   clk_i      : system clock
//   rst_n      : synchronous reset, active HIGH despite the name
//   uart_rx_i  : asynchronous serial line, idle high
//   buad_set_i : baud select 0..7 (1200 .. 115200)
//   rx_data_o  : last correctly framed byte, held until the next good frame
//   rx_done_o  : one-cycle pulse when rx_data_o is updated
//   rx_error_o : one-cycle pulse when the stop bit is sampled low
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       uart_rx_i,
    input  logic [2:0] buad_set_i,
    output logic [7:0] rx_data_o,
    output logic       rx_done_o,
    output logic       rx_error_o
);
    import uart_rx_pkg::*;

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_S2   = TW'(OVERSAMPLE / 2 + 1);

    // [0],[1] form the synchronizer; [2] is the delayed copy for edge detect
    logic [2:0]    sync_q;
    logic          rx_s;
    logic          fall;

    rx_state_t     state_q,    state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q,  bit_cnt_d;
    logic [1:0]    vote_q,     vote_d;
    logic [7:0]    shift_q,    shift_d;
    logic [15:0]   div_q,      div_d;
    logic [7:0]    data_q,     data_d;
    logic          done_q,     done_d;
    logic          err_q,      err_d;

    logic          tick;
    logic          baud_clear;
    logic          maj;

    assign rx_s       = sync_q[1];
    assign fall       = sync_q[2] & ~sync_q[1];
    assign baud_clear = (state_q == IDLE);
    // third sample is taken live at the decision tick
    assign maj        = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

    uart_baud_gen u_baud_gen (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .clear_i (baud_clear),
        .div_i   (div_q),
        .tick_o  (tick)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        vote_d     = vote_q;
        shift_d    = shift_q;
        div_d      = div_q;
        data_d     = data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (state_q == IDLE) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            // a line stuck low after a framing error produces no edge here,
            // so a break reports once and waits for the line to go high
            if (fall) begin
                div_d   = baud_div(CLK_FREQ, buad_set_i, OVERSAMPLE);
                state_d = START;
            end
        end else if (tick) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
            if (tick_cnt_q == TICK_S0) vote_d[0] = rx_s;
            if (tick_cnt_q == TICK_S1) vote_d[1] = rx_s;
            if (tick_cnt_q == TICK_S2) begin
                case (state_q)
                    START: begin
                        state_d = maj ? IDLE : DATA;
                    end
                    DATA: begin
                        shift_d = {maj, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                    STOP: begin
                        if (maj) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            err_d  = 1'b1;
                        end
                        state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n) begin
            sync_q     <= 3'b111;
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            vote_q     <= '0;
            shift_q    <= '0;
            div_q      <= 16'd1;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], uart_rx_i};
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            vote_q     <= vote_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rx_data_o  = data_q;
    assign rx_done_o  = done_q;
    assign rx_error_o = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. The clock frequency is scaled down so that
// every baud divisor is an exact integer and a 1200-baud frame stays short.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CLK_HZ = 1_843_200;
    localparam int unsigned BAUD [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       line = 1'b1;
    logic [2:0] sel  = 3'd5;
    logic [7:0] data;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    uart_rx #(.CLK_FREQ(CLK_HZ), .OVERSAMPLE(16)) dut (
        .clk_i      (clk),
        .rst_n      (rst),
        .uart_rx_i  (line),
        .buad_set_i (sel),
        .rx_data_o  (data),
        .rx_done_o  (done),
        .rx_error_o (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: bytes still owed, errors owed/seen, last good byte
    logic [7:0] exp_q [$];
    logic [7:0] model_data = 8'h00;
    int         exp_err    = 0;
    int         seen_err   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bit_clks(input logic [2:0] s);
        return int'(CLK_HZ / BAUD[s]);
    endfunction

    task automatic hold(input logic v, input int n);
        line = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        int bc;
        bc = bit_clks(sel);
        if (stop_ok) exp_q.push_back(b);
        else         exp_err++;
        hold(1'b0, bc);
        for (int i = 0; i < 8; i++) hold(b[i], bc);
        hold(stop_ok, bc);
    endtask

    task automatic settle(input string tag);
        hold(1'b1, 2 * bit_clks(sel));
        check_eq({tag, "_pending"}, exp_q.size(), 0);
        check_eq({tag, "_errors"}, seen_err, exp_err);
        check_eq({tag, "_data"}, data, model_data);
    endtask

    // strobe monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (done || err) check_eq("strobe_exclusive", {31'b0, done & err}, 0);
            if (done) begin
                check_eq("done_expected", {31'b0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    model_data = exp_q.pop_front();
                    check_eq("rx_data", data, model_data);
                end
            end
            if (err) begin
                seen_err++;
                check_eq("data_held_on_error", data, model_data);
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        logic       rs;
        int         bc;

        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("reset_data", data, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_err",  err,  0);
        rst = 1'b0;
        hold(1'b1, 2 * bit_clks(sel));

        // single good frame
        send_frame(8'h55, 1'b1);
        settle("byte55");

        // back-to-back, no idle
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        settle("b2b");

        // framing error
        send_frame(8'h3C, 1'b0);
        settle("framing");

        // short glitch on idle line, then a real frame
        hold(1'b0, bit_clks(sel) / 13);
        hold(1'b1, bit_clks(sel));
        check_eq("glitch_errors", seen_err, exp_err);
        check_eq("glitch_data", data, model_data);
        send_frame(8'h81, 1'b1);
        settle("after_glitch");

        // baud sweep
        sel = 3'd0; hold(1'b1, bit_clks(sel)); send_frame(8'hC6, 1'b1); settle("sel0");
        sel = 3'd3; hold(1'b1, bit_clks(sel)); send_frame(8'hC6, 1'b1); settle("sel3");
        sel = 3'd7; hold(1'b1, bit_clks(sel)); send_frame(8'hC6, 1'b1); settle("sel7");

        // reset during data bit 4 of 0x5A (bit 4 is 1, so no edge after release)
        sel = 3'd5;
        bc  = bit_clks(sel);
        rb  = 8'h5A;
        hold(1'b0, bc);
        for (int i = 0; i < 4; i++) hold(rb[i], bc);
        hold(rb[4], bc / 2);
        rst = 1'b1;
        model_data = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("midreset_data", data, 0);
        check_eq("midreset_done", done, 0);
        check_eq("midreset_err",  err,  0);
        rst = 1'b0;
        hold(1'b1, 12 * bc);
        check_eq("midreset_errors", seen_err, exp_err);
        check_eq("midreset_pending", exp_q.size(), 0);
        send_frame(8'h7E, 1'b1);
        settle("after_reset");

        // break: 20 bit times low gives exactly one error
        exp_err++;
        hold(1'b0, 20 * bc);
        check_eq("break_errors", seen_err, exp_err);
        hold(1'b1, 2 * bc);
        check_eq("break_recovered_errors", seen_err, exp_err);
        rb = 8'($urandom);
        send_frame(rb, 1'b1);
        settle("after_break");

        // randomized frames, rates and gaps
        for (int i = 0; i < 12; i++) begin
            sel = 3'($urandom_range(4, 7));
            rb  = 8'($urandom);
            rs  = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs);
            // after a bad stop the line must rise before a new start edge
            if (!rs || $urandom_range(0, 1) == 1) hold(1'b1, bit_clks(sel));
        end
        settle("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
